// File: rtl/fifo_serial_tx.sv
// Drains 9-bit words from a FIFO through a one-word holding register and sends each one as a
// serial frame: start bit, LSB-first data, even parity, stop bit.
module fifo_serial_tx #(
  parameter int DW           = 9,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pin,
  input  logic [DW-1:0]    din,
  output logic             rd,
  output logic             sout,
  output logic             busy,
  output logic [CNT_W-1:0] frames
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [7:0]    CNT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [DW-1:0]    sh_q, sh_d;
  logic             par_q, par_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             sout_q, sout_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             last_cnt;
  logic             load;

  assign rd     = ~hold_v_q;
  assign sout   = sout_q;
  assign busy   = (state_q != IDLE) || hold_v_q;
  assign frames = frames_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    par_d     = par_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    frames_d  = frames_q;
    load      = 1'b0;
    last_cnt  = (clk_cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (hold_v_q) load = 1'b1;
      end
      START: begin
        if (last_cnt) begin
          state_d   = DATA;
          clk_cnt_d = 8'd0;
          bit_idx_d = '0;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (last_cnt) begin
          clk_cnt_d = 8'd0;
          sh_d      = sh_q >> 1;
          if (bit_idx_q == BIT_LAST) state_d = PARITY;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      PARITY: begin
        if (last_cnt) begin
          state_d   = STOP;
          clk_cnt_d = 8'd0;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (last_cnt) begin
          frames_d  = frames_q + CNT_W'(1);
          clk_cnt_d = 8'd0;
          // A waiting word goes straight into START so back-to-back frames have no idle gap.
          if (hold_v_q) load = 1'b1;
          else          state_d = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = 8'd0;
      end
    endcase

    if (load) begin
      sh_d      = hold_q;
      par_d     = ^hold_q;
      hold_v_d  = 1'b0;
      state_d   = START;
      clk_cnt_d = 8'd0;
    end

    // rd is low whenever hold_v is set, so an accept never collides with a load.
    if (pin && rd) begin
      hold_d   = din;
      hold_v_d = 1'b1;
    end

    // The line level is derived from the next state so sout is a clean flop output.
    case (state_d)
      IDLE:    sout_d = 1'b1;
      START:   sout_d = 1'b0;
      DATA:    sout_d = sh_d[0];
      PARITY:  sout_d = par_d;
      default: sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= 8'd0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      sout_q    <= 1'b1;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      sout_q    <= sout_d;
      frames_q  <= frames_d;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Randomized bench for fifo_serial_tx: a frame-timeline model predicts sout/rd/busy/frames
// every cycle; a second small-counter instance exercises frames wrap-around.
module tb_fifo_serial_tx;

  localparam int FRAME = 48;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pin = 1'b0;
  logic [8:0] din = '0;
  logic       rd, sout, busy;
  logic [15:0] frames;

  logic       rst2_n = 1'b1;
  logic       pin2 = 1'b0;
  logic [8:0] din2 = '0;
  logic       rd2, sout2, busy2;
  logic [3:0] frames2;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: a frame is a 48-cycle timeline; m_rem counts the cycles left in it.
  logic [8:0] m_hold;
  logic       m_hold_v;
  logic [8:0] m_word;
  int         m_rem;
  int         m_frames;
  int         m_accepts;

  always #5 clock = ~clock;

  fifo_serial_tx #(.DW(9), .CLKS_PER_BIT(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .pin(pin), .din(din),
    .rd(rd), .sout(sout), .busy(busy), .frames(frames)
  );

  fifo_serial_tx #(.DW(9), .CLKS_PER_BIT(2), .CNT_W(4)) dut_wrap (
    .clock(clock), .reset(rst2_n), .pin(pin2), .din(din2),
    .rd(rd2), .sout(sout2), .busy(busy2), .frames(frames2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_sout();
    int b;
    if (m_rem == 0) return 1'b1;
    b = (FRAME - m_rem) / 4;
    if (b == 0) return 1'b0;
    if (b <= 9) return m_word[b-1];
    if (b == 10) return ^m_word;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_hold = '0; m_hold_v = 1'b0; m_word = '0; m_rem = 0; m_frames = 0;
  endtask

  task automatic model_step(input logic p, input logic [8:0] d);
    logic acc;
    acc = p && !m_hold_v;
    if (m_rem == 0) begin
      if (m_hold_v) begin
        m_word = m_hold; m_hold_v = 1'b0; m_rem = FRAME;
      end
    end else if (m_rem == 1) begin
      m_frames = (m_frames + 1) % 65536;
      if (m_hold_v) begin
        m_word = m_hold; m_hold_v = 1'b0; m_rem = FRAME;
      end else begin
        m_rem = 0;
      end
    end else begin
      m_rem--;
    end
    if (acc) begin
      m_hold = d; m_hold_v = 1'b1; m_accepts++;
    end
  endtask

  task automatic check_all();
    check("sout", 32'(sout), 32'(exp_sout()));
    check("rd", 32'(rd), 32'(!m_hold_v));
    check("busy", 32'(busy), 32'((m_rem != 0) || m_hold_v));
    check("frames", 32'(frames), 32'(m_frames));
  endtask

  task automatic cyc(input logic p, input logic [8:0] d);
    pin = p;
    din = d;
    @(posedge clock);
    if (reset) model_step(p, d);
    else       model_clear();
    #1;
    check_all();
  endtask

  initial begin
    logic [11:0] seq;
    logic [11:0] exp_seq;
    int          base_acc;
    int          e;
    int          exp_f;
    bit          reached;

    m_accepts = 0;
    model_clear();
    exp_seq = 12'hF4A;
    seq = '0;

    // Reset held with pin high: nothing may be accepted.
    #2;
    reset = 1'b0;
    rst2_n = 1'b0;
    #1;
    check_all();
    for (int i = 0; i < 4; i++) cyc(1'b1, 9'($urandom));
    check("reset_no_accept", 32'(m_accepts), 32'd0);
    reset = 1'b1;
    #1;
    check_all();

    // Single frame of 9'h1A5.
    cyc(1'b1, 9'h1A5);
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 9'($urandom));
      if (m_rem != 0 && ((FRAME - m_rem) % 4) == 1) seq[(FRAME - m_rem) / 4] = sout;
    end
    check("single_seq", 32'(seq), 32'(exp_seq));
    check("single_frames", 32'(frames), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // Back-to-back: 9'h000 first, then 9'h1FF for every later accept.
    base_acc = m_accepts;
    for (int i = 0; i < 110; i++)
      cyc(1'b1, (m_accepts == base_acc) ? 9'h000 : 9'h1FF);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      cyc(1'b0, 9'($urandom));
      if (m_rem == 0 && !m_hold_v) reached = 1'b1;
    end
    check("b2b_drained", 32'(reached), 32'd1);

    // Mid-frame reset during data bit 4.
    cyc(1'b1, 9'($urandom));
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      cyc(1'b0, 9'($urandom));
      if (m_rem == 27) reached = 1'b1;
    end
    check("mid_reached_bit4", 32'(reached), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_sout", 32'(sout), 32'd1);
    model_clear();
    check_all();
    for (int i = 0; i < 3; i++) cyc(1'b1, 9'($urandom));
    reset = 1'b1;
    cyc(1'b1, 9'($urandom));
    for (int i = 0; i < 55; i++) cyc(1'b0, 9'($urandom));
    check("mid_after_frames", 32'(frames), 32'd1);

    // Back-pressure: random pin and data.
    base_acc = m_accepts;
    for (int i = 0; i < 7000; i++)
      cyc(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 9'($urandom));
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      cyc(1'b0, 9'($urandom));
      if (m_rem == 0 && !m_hold_v) reached = 1'b1;
    end
    check("bp_drained", 32'(reached), 32'd1);
    check("bp_frames", 32'(frames), 32'((1 + m_accepts - base_acc) % 65536));

    // Wrap: 4-bit counter, 24-cycle frames, continuous pin.
    @(posedge clock);
    #1;
    rst2_n = 1'b1;
    check("wrap_reset_frames", 32'(frames2), 32'd0);
    for (e = 1; e <= 420; e++) begin
      pin2 = 1'b1;
      din2 = 9'($urandom);
      @(posedge clock);
      #1;
      exp_f = (e >= 2) ? (((e - 2) / 24) % 16) : 0;
      check("wrap_frames", 32'(frames2), 32'(exp_f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
